// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache controller with line-wide memory handshake
module dcache_ctrl #(
  parameter int INDEX_W = 4,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 27 - INDEX_W;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  state_t state;
  logic [LINE_W-1:0] data_q [LINES];
  logic [TAG_W-1:0] tag_q [LINES];
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] miss_tag, tag;
  logic [INDEX_W-1:0] miss_idx, idx;
  logic [31:0] data_hold;
  logic [7:0] woff;
  logic hit, evict;
  assign woff = {cpu_addr_i[4:2], 5'b0};
  assign idx = cpu_addr_i[4+INDEX_W:5];
  assign tag = cpu_addr_i[31:5+INDEX_W];
  assign hit = cpu_req_i & valid_q[idx] & (tag_q[idx] == tag);
  assign evict = valid_q[idx] & dirty_q[idx];
  assign cpu_stall_o = (state != IDLE) | (cpu_req_i & ~hit);
  // load data is live on a hit, otherwise the last returned word is held
  assign cpu_data_o = (state == IDLE && hit && !cpu_we_i) ? data_q[idx][woff +: 32] : data_hold;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      data_hold <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
    end else begin
      case (state)
        IDLE:
          if (hit) begin
            if (cpu_we_i) begin
              data_q[idx][woff +: 32] <= cpu_data_i;
              dirty_q[idx] <= 1'b1;
            end else data_hold <= data_q[idx][woff +: 32];
          end else if (cpu_req_i) begin
            miss_tag <= tag;
            miss_idx <= idx;
            mem_req_o <= 1'b1;
            mem_we_o <= evict;
            mem_addr_o <= evict ? {tag_q[idx], idx, 5'b0} : {tag, idx, 5'b0};
            mem_data_o <= data_q[idx];
            state <= evict ? WRITEBACK : REFILL;
          end
        WRITEBACK:
          if (mem_ack_i) begin
            dirty_q[miss_idx] <= 1'b0;
            mem_we_o <= 1'b0;
            mem_addr_o <= {miss_tag, miss_idx, 5'b0};
            state <= REFILL;
          end
        REFILL:
          if (mem_ack_i) begin
            data_q[miss_idx] <= mem_data_i;
            tag_q[miss_idx] <= miss_tag;
            valid_q[miss_idx] <= 1'b1;
            dirty_q[miss_idx] <= 1'b0;
            mem_req_o <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data-cache controller between the MEM pipeline stage and off-chip data memory.
- Holds the tag, valid, dirty and data arrays.
- Services MemRead/MemWrite word accesses from the pipeline and asserts a stall while line refills and write-backs are in progress.
- Talks to memory through a 256-bit line-wide req/ack handshake.

Parameters:
- INDEX_W, 4, number of index bits; the cache has 2^INDEX_W lines.
- LINE_W, 256, line width in bits (32 bytes, 8 words); fixed by the memory interface.

Ports:
- clk_i  in  1  clock; everything samples on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- cpu_req_i  in  1  access request (MemRead or MemWrite of the MEM stage).
- cpu_we_i  in  1  1 = store word, 0 = load word.
- cpu_addr_i  in  32  byte address. Fields: [4:2] word, [4+INDEX_W:5] index, [31:5+INDEX_W] tag.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data.
- cpu_stall_o  out  1  freeze the pipeline.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  32  line address; bits [4:0] are always 0.
- mem_data_o  out  256  write-back line.
- mem_data_i  in  256  fetched line.
- mem_ack_i  in  1  one-cycle completion pulse from memory.

Behaviour:
- Reset: state=IDLE; all valid and dirty bits cleared; cpu_stall_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, cpu_data_o=0. Data and tag arrays are not reset.
- hit = cpu_req_i & valid[idx] & (tag[idx]==addr tag), combinational.
- States: IDLE, WRITEBACK, REFILL.
- IDLE, cpu_req_i=0:
  - cpu_stall_o=0, no memory traffic.
  - cpu_data_o is don't-care; hold the last value.
- IDLE, hit, load:
  - cpu_data_o = selected word of the line, combinational, same cycle.
  - cpu_stall_o=0.
- IDLE, hit, store:
  - cpu_stall_o=0.
  - At the clock edge, the selected word of the line takes cpu_data_i and dirty[idx] is set to 1.
  - Other words of the line are unchanged.
- IDLE, miss (cpu_req_i=1, not hit):
  - cpu_stall_o=1 combinationally in the same cycle.
  - If valid[idx] & dirty[idx]: go to WRITEBACK. Otherwise: go to REFILL.
- WRITEBACK:
  - mem_req_o=1, mem_we_o=1, mem_addr_o={old tag, idx, 5'b0}, mem_data_o=stored line.
  - These outputs are held stable until mem_ack_i=1.
  - On ack: dirty[idx]=0, go to REFILL.
- REFILL:
  - mem_req_o=1, mem_we_o=0, mem_addr_o={new tag, idx, 5'b0}.
  - On ack: line=mem_data_i, tag=new tag, valid=1, dirty=0, go to IDLE.
- The first IDLE cycle after REFILL re-evaluates the access, which is now a hit:
  - a load completes in that cycle;
  - a store merges into the line and sets dirty.
- cpu_stall_o=1 in every WRITEBACK and REFILL cycle.
- Latency:
  - Clean miss: 1 + (cycles to ack) + 1, counted from the miss cycle to the first unstalled cycle.
  - Dirty miss adds the write-back ack wait.
- mem_req_o stays high across the WRITEBACK to REFILL transition. Memory treats the cycle after an ack as a new request.
- mem_ack_i arriving while not in WRITEBACK or REFILL is ignored.
- The pipeline holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_data_i stable while cpu_stall_o=1. The controller latches the miss tag and index at miss detection and uses the latched values for mem_addr_o.
- Reset mid-operation:
  - State goes to IDLE, mem_req_o goes to 0 the next cycle, all lines are invalidated.
  - Dirty data is discarded, not written back.
  - A pending ack after reset is ignored.
- Simultaneous mem_ack_i and rst_i: reset wins.

Test Plan:
- Cold load of 0x0000_0040 (reset state):
  - Required: stall=1, then REFILL request with mem_addr_o=0x0000_0040, mem_we_o=0.
  - Ack after 10 cycles with line word2=0xDEADBEEF; load of 0x48 then returns 0xDEADBEEF with stall=0 one cycle after the ack.
- Store hit:
  - After the refill above, store 0x1234_5678 to 0x44.
  - Required: no stall, no mem_req_o. A following load of 0x44 returns 0x1234_5678 and other words are unchanged.
- Dirty conflict eviction, INDEX_W=4:
  - Load 0x0000_0240 (same index, different tag) after the store above.
  - Required: WRITEBACK of addr 0x40 with word1=0x12345678, then REFILL of 0x240, then hit.
- Clean conflict:
  - Evict a never-written line.
  - Required: no WRITEBACK phase; mem_we_o is never 1.
- Ack delay sweep of 1, 5 and 50 cycles:
  - Required: mem_addr_o, mem_we_o and mem_data_o stay constant until the ack.
  - Stall length equals the ack delay + 1 per phase.
- Reset during REFILL:
  - Assert rst_i for 1 cycle mid-wait.
  - Required: mem_req_o=0 the next cycle, stall=0, a late ack is ignored, and a re-access of the same address misses again.
